// File: rtl/inmem_port_b_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pp_loader_pkg                                                  |
// | Brief   : Shared FSM state type and CRC8 helpers for the port-B loader.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package pp_loader_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        READ   = 3'd2,
        RDRAIN = 3'd3,
        DONE   = 3'd4
    } loader_state_t;

    // MSB-first, no reflection, no final XOR
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] crc8_word(input logic [7:0]  crc,
                                             input logic [31:0] data,
                                             input logic [3:0]  be,
                                             input logic [7:0]  poly);
        logic [7:0] c;
        c = crc;
        for (int lane = 3; lane >= 0; lane--) begin
            if (be[lane]) begin
                c = crc8_byte(c, data[8*lane +: 8], poly);
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inmem_port_b_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : inmem_port_b_loader_if                                         |
// | Brief   : Word stream plus inmem port-B bus seen from the loader.        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface inmem_port_b_loader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] s_data_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic              mem_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_we_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;

    modport master (
        input  s_data_i, s_valid_i, mem_data_i,
        output s_ready_o, mem_en_o, mem_addr_o, mem_we_o, mem_data_o
    );

    modport slave (
        output s_data_i, s_valid_i, mem_data_i,
        input  s_ready_o, mem_en_o, mem_addr_o, mem_we_o, mem_data_o
    );
endinterface
`default_nettype wire

// File: rtl/inmem_port_b_loader_crc8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : crc8_word_acc                                                  |
// | Brief   : Registered CRC8 accumulator over byte-enabled 32-bit words.    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module crc8_word_acc
    import pp_loader_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        clear_i,
    input  wire logic        en_i,
    input  wire logic [31:0] data_i,
    input  wire logic [3:0]  be_i,
    output logic      [7:0]  crc_o
);
    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = 8'h00;
        end else if (en_i) begin
            crc_d = crc8_word(crc_q, data_i, be_i, POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;
endmodule
`default_nettype wire

// File: rtl/inmem_port_b_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : inmem_port_b_loader                                            |
// | Brief   : Streams words into inmem port B with CRC8; optional readback   |
// |           verification enabled by INMEM_READBACK_CHECK_EN.               |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module inmem_port_b_loader
    import pp_loader_pkg::*;
#(
    parameter int         ADDR_W   = 14,
    parameter int         DATA_W   = 32,
    parameter int         CNT_W    = 12,
    parameter logic [7:0] CRC_POLY = CRC8_POLY
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start_i,
    input  wire logic [ADDR_W-1:0] base_addr_i,
    input  wire logic [CNT_W-1:0]  word_cnt_i,
    input  wire logic [3:0]        last_we_i,
    inmem_port_b_loader_if.master  bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic      [7:0]        crc_o,
    output logic                   err_o
);
    loader_state_t     state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  idx_q;
    logic [3:0]        last_be_q;
    logic              mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_we_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              busy_q;
    logic              done_q;

    logic              w_start;
    logic              w_ready;
    logic              w_hs;
    logic              w_last;
    logic [3:0]        w_wr_be;
    logic [7:0]        w_wcrc;
    logic [1:0]        w_unused_base_lsb;

    assign w_start           = (state_q == IDLE) && start_i;
    assign w_ready           = (state_q == WRITE);
    assign w_hs              = bus.s_valid_i && w_ready;
    assign w_last            = (idx_q == cnt_q - CNT_W'(1));
    assign w_wr_be           = w_last ? last_be_q : 4'hF;
    assign w_unused_base_lsb = base_addr_i[1:0];

    crc8_word_acc #(.POLY(CRC_POLY)) u_wr_crc (
        .clk     (clk),
        .reset   (reset),
        .clear_i (w_start),
        .en_i    (w_hs),
        .data_i  (bus.s_data_i),
        .be_i    (w_wr_be),
        .crc_o   (w_wcrc)
    );

`ifdef INMEM_READBACK_CHECK_EN
    logic       mem_last_q;
    logic       rd_vld_q;
    logic       rd_last_q;
    logic       err_q;
    logic [3:0] w_rd_be;
    logic [7:0] w_rcrc;
    logic [7:0] w_rcrc_final;

    assign w_rd_be = rd_last_q ? last_be_q : 4'hF;

    crc8_word_acc #(.POLY(CRC_POLY)) u_rd_crc (
        .clk     (clk),
        .reset   (reset),
        .clear_i (w_start),
        .en_i    (rd_vld_q),
        .data_i  (bus.mem_data_i),
        .be_i    (w_rd_be),
        .crc_o   (w_rcrc)
    );

    // The last read word lands during DONE, so fold it in combinationally for the compare
    assign w_rcrc_final = rd_vld_q ? crc8_word(w_rcrc, bus.mem_data_i, w_rd_be, CRC_POLY)
                                   : w_rcrc;
    assign err_o = err_q;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^bus.mem_data_i;
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            last_be_q  <= 4'h0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_we_q   <= 4'h0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef INMEM_READBACK_CHECK_EN
            mem_last_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 4'h0;
            done_q   <= 1'b0;
`ifdef INMEM_READBACK_CHECK_EN
            rd_vld_q  <= mem_en_q && (mem_we_q == 4'h0);
            rd_last_q <= mem_last_q;
`endif
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q    <= {base_addr_i[ADDR_W-1:2], 2'b00};
                        addr_q    <= {base_addr_i[ADDR_W-1:2], 2'b00};
                        cnt_q     <= word_cnt_i;
                        idx_q     <= '0;
                        last_be_q <= (last_we_i == 4'h0) ? 4'hF : last_we_i;
                        busy_q    <= 1'b1;
                        state_q   <= (word_cnt_i == '0) ? DONE : WRITE;
`ifdef INMEM_READBACK_CHECK_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    if (w_hs) begin
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= w_wr_be;
                        mem_addr_q <= addr_q;
                        mem_data_q <= bus.s_data_i;
`ifdef INMEM_READBACK_CHECK_EN
                        mem_last_q <= w_last;
`endif
                        if (w_last) begin
                            idx_q  <= '0;
                            addr_q <= base_q;
`ifdef INMEM_READBACK_CHECK_EN
                            state_q <= READ;
`else
                            state_q <= DONE;
`endif
                        end else begin
                            idx_q  <= idx_q + CNT_W'(1);
                            addr_q <= addr_q + ADDR_W'(4);
                        end
                    end
                end
`ifdef INMEM_READBACK_CHECK_EN
                READ: begin
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= addr_q;
                    mem_last_q <= w_last;
                    addr_q     <= addr_q + ADDR_W'(4);
                    idx_q      <= idx_q + CNT_W'(1);
                    if (w_last) begin
                        state_q <= RDRAIN;
                    end
                end
                RDRAIN: begin
                    state_q <= DONE;
                end
`endif
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef INMEM_READBACK_CHECK_EN
                    err_q   <= (w_rcrc_final != w_wcrc);
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready_o  = w_ready;
    assign bus.mem_en_o   = mem_en_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_we_o   = mem_we_q;
    assign bus.mem_data_o = mem_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign crc_o          = w_wcrc;
endmodule
`default_nettype wire

// File: tb/tb_inmem_port_b_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_inmem_port_b_loader                                         |
// | Brief   : Randomized bench with per-cycle expectation tables.            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_inmem_port_b_loader;
    localparam int NCYC = 8192;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [13:0] base_addr_i = '0;
    logic [11:0] word_cnt_i = '0;
    logic [3:0]  last_we_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  crc_o;
    logic        err_o;

    inmem_port_b_loader_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    inmem_port_b_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .word_cnt_i  (word_cnt_i),
        .last_we_i   (last_we_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .crc_o       (crc_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int en_count = 0;
    bit chk_on = 1'b0;

    bit          exp_ready [NCYC];
    bit          exp_en    [NCYC];
    bit          exp_busy  [NCYC];
    bit          exp_done  [NCYC];
    bit          exp_err   [NCYC];
    logic [13:0] exp_addr  [NCYC];
    logic [3:0]  exp_we    [NCYC];
    logic [31:0] exp_data  [NCYC];
    logic [7:0]  exp_crc   [NCYC];
    logic [13:0] wr_log[$];

    // Port-B memory with one-cycle read latency and a one-shot readback corruption
    logic [31:0] mem [4096];
    logic [31:0] rdata = '0;
    bit          corrupt_arm = 1'b0;
    bit          corrupt_used = 1'b0;
    assign bus.mem_data_i = rdata;

    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o != 4'h0) begin
                for (int l = 0; l < 4; l++) begin
                    if (bus.mem_we_o[l]) mem[bus.mem_addr_o[13:2]][8*l +: 8] <= bus.mem_data_o[8*l +: 8];
                end
            end else begin
                if (corrupt_arm && !corrupt_used) begin
                    rdata        <= mem[bus.mem_addr_o[13:2]] ^ 32'h0000_0001;
                    corrupt_used <= 1'b1;
                end else begin
                    rdata <= mem[bus.mem_addr_o[13:2]];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] crc8_of(input byte_q_t bytes);
        logic [7:0] c;
        c = 8'h00;
        foreach (bytes[i]) begin
            c = c ^ bytes[i];
            repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (chk_on && cyc < NCYC) begin
            chk("s_ready", bus.s_ready_o, exp_ready[cyc]);
            chk("mem_en", bus.mem_en_o, exp_en[cyc]);
            chk("busy", busy_o, exp_busy[cyc]);
            chk("done", done_o, exp_done[cyc]);
            if (exp_en[cyc]) begin
                chk("mem_addr", bus.mem_addr_o, exp_addr[cyc]);
                chk("mem_we", bus.mem_we_o, exp_we[cyc]);
                if (exp_we[cyc] != 4'h0) chk("mem_data", bus.mem_data_o, exp_data[cyc]);
            end
            if (exp_done[cyc]) begin
                chk("crc", crc_o, exp_crc[cyc]);
                chk("err", err_o, exp_err[cyc]);
            end
            if (bus.mem_en_o === 1'b1) en_count++;
            if (bus.mem_en_o === 1'b1 && bus.mem_we_o != 4'h0) wr_log.push_back(bus.mem_addr_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (cyc >= NCYC - 64) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, NCYC - 64);
            $fatal(1);
        end
    endtask

    // dsel: 0 random data, 1 word index+1, 2 fixed AABBCCDD
    task automatic run_load(input logic [13:0] base, input int cnt, input logic [3:0] lw,
                            input int vprob, input bit toggle, input int dsel, input bit corrupt);
        logic [13:0] b;
        logic [3:0]  elw;
        logic [31:0] d;
        byte_q_t     bq;
        int          k, i, c0, h, dn;
        bit          v;
        b   = {base[13:2], 2'b00};
        elw = (lw == 4'h0) ? 4'hF : lw;
        c0  = cyc;
        start_i = 1'b1; base_addr_i = base; word_cnt_i = 12'(cnt); last_we_i = lw;
        bus.s_valid_i = 1'b0;
        tick();
        start_i = 1'b0;
        base_addr_i = 14'($urandom); word_cnt_i = 12'($urandom); last_we_i = 4'($urandom);
        k = 0;
        i = 0;
        while (k < cnt) begin
            exp_ready[cyc] = 1'b1;
            exp_busy[cyc]  = 1'b1;
            v = toggle ? (i % 2 == 0) : ($urandom_range(99) < vprob);
            d = (dsel == 1) ? 32'(k + 1) : (dsel == 2) ? 32'hAABB_CCDD : $urandom;
            bus.s_valid_i = v;
            bus.s_data_i  = d;
            start_i = ($urandom_range(1) == 1);
            if (v) begin
                exp_en[cyc+1]   = 1'b1;
                exp_addr[cyc+1] = b + 14'(4 * k);
                exp_we[cyc+1]   = (k == cnt - 1) ? elw : 4'hF;
                exp_data[cyc+1] = d;
                for (int l = 3; l >= 0; l--) begin
                    if (exp_we[cyc+1][l]) bq.push_back(d[8*l +: 8]);
                end
                k++;
            end
            i++;
            tick();
        end
        start_i = 1'b0;
        bus.s_valid_i = 1'b0;
        if (cnt == 0) begin
            dn = c0 + 2;
        end else begin
            h = cyc - 1;
`ifdef INMEM_READBACK_CHECK_EN
            for (int r = 0; r < cnt; r++) begin
                exp_en[h+2+r]   = 1'b1;
                exp_addr[h+2+r] = b + 14'(4 * r);
                exp_we[h+2+r]   = 4'h0;
            end
            dn = h + cnt + 3;
`else
            dn = h + 2;
`endif
        end
        for (int c = c0 + 1; c < dn; c++) exp_busy[c] = 1'b1;
        exp_done[dn] = 1'b1;
        exp_crc[dn]  = crc8_of(bq);
`ifdef INMEM_READBACK_CHECK_EN
        exp_err[dn]  = corrupt;
`else
        exp_err[dn]  = 1'b0;
        if (corrupt) exp_err[dn] = 1'b0;
`endif
        while (cyc < dn) tick();
    endtask

    initial begin
        logic [13:0] t1a [4];
        logic [13:0] t4a [3];
        int          en0;
        t1a = '{14'h0100, 14'h0104, 14'h0108, 14'h010C};
        t4a = '{14'h3FF8, 14'h3FFC, 14'h0000};
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        repeat (3) tick();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_en", bus.mem_en_o, 1'b0);
        chk("rst_ready", bus.s_ready_o, 1'b0);
        chk("rst_crc", crc_o, 8'h00);
        chk("rst_err", err_o, 1'b0);
        reset = 1'b1;
        chk_on = 1'b1;
        tick();

        // Streamed load with valid held high
        wr_log.delete();
        run_load(14'h0100, 4, 4'hF, 100, 1'b0, 1, 1'b0);
        chk("t1_nwr", wr_log.size(), 4);
        for (int j = 0; j < 4 && j < wr_log.size(); j++) chk("t1_addr", wr_log[j], t1a[j]);

        // Single word with partial byte enables
        run_load(14'h0200, 1, 4'b0011, 100, 1'b0, 2, 1'b0);
        chk("t2_crc", crc_o, 8'h0C);

        // Bubbles
        wr_log.delete();
        run_load(14'h0303, 2, 4'h0, 0, 1'b1, 0, 1'b0);
        chk("t3_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("t3_addr0", wr_log[0], 14'h0300);
            chk("t3_addr1", wr_log[1], 14'h0304);
        end

        // Address wrap
        wr_log.delete();
        run_load(14'h3FF8, 3, 4'hF, 100, 1'b0, 0, 1'b0);
        chk("t4_nwr", wr_log.size(), 3);
        for (int j = 0; j < 3 && j < wr_log.size(); j++) chk("t4_addr", wr_log[j], t4a[j]);
        chk("t4_err", err_o, 1'b0);

        // Zero-length load
        en0 = en_count;
        run_load(14'h0440, 0, 4'hF, 100, 1'b0, 0, 1'b0);
        chk("t0_crc", crc_o, 8'h00);
        chk("t0_no_en", en_count - en0, 0);

        // Reset in the middle of an 8-word load
        start_i = 1'b1; base_addr_i = 14'h0500; word_cnt_i = 12'd8; last_we_i = 4'hF;
        tick();
        start_i = 1'b0;
        for (int j = 0; j < 2; j++) begin
            exp_ready[cyc] = 1'b1;
            exp_busy[cyc]  = 1'b1;
            bus.s_valid_i  = 1'b1;
            bus.s_data_i   = $urandom;
            exp_en[cyc+1]   = 1'b1;
            exp_addr[cyc+1] = 14'h0500 + 14'(4 * j);
            exp_we[cyc+1]   = 4'hF;
            exp_data[cyc+1] = bus.s_data_i;
            tick();
        end
        exp_ready[cyc] = 1'b1;
        exp_busy[cyc]  = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.s_valid_i = 1'b0;
        chk("t5_en", bus.mem_en_o, 1'b0);
        chk("t5_addr", bus.mem_addr_o, 14'h0000);
        chk("t5_we", bus.mem_we_o, 4'h0);
        chk("t5_data", bus.mem_data_o, 32'h0);
        chk("t5_busy", busy_o, 1'b0);
        chk("t5_crc", crc_o, 8'h00);
        chk("t5_err", err_o, 1'b0);
        tick();
        wr_log.delete();
        run_load(14'h0840, 3, 4'b1000, 100, 1'b0, 0, 1'b0);
        chk("t5_newbase", (wr_log.size() > 0) ? wr_log[0] : 14'h3FFF, 14'h0840);

`ifdef INMEM_READBACK_CHECK_EN
        corrupt_arm = 1'b1;
        run_load(14'h0A00, 3, 4'hF, 100, 1'b0, 0, 1'b1);
        chk("t6_err_corrupt", err_o, 1'b1);
        run_load(14'h0B00, 3, 4'b0101, 70, 1'b0, 0, 1'b0);
        chk("t6_err_clean", err_o, 1'b0);
`endif

        // Randomized loads
        for (int n = 0; n < 14; n++) begin
            run_load(14'($urandom), $urandom_range(9), 4'($urandom), $urandom_range(100, 30),
                     1'b0, 0, 1'b0);
        end

        tick();
        tick();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
`default_nettype wire
